branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Parametrised, registered branch resolver for the 16-bit datapath. Compares
//  rd1 against rd15 under a selectable condition and computes the branch target.
//  Also sequences a fixed-length pipeline flush after a taken branch.
//  Sits between the register-read stage and PC select; drives pcsrc to the PC mux.
// PARAMETERS
//  WIDTH         16  operand width of rd1/rd15
//  PC_W          16  PC, offset and target width
//  FLUSH_CYCLES   2  cycles flush is held after a taken branch (0 = no flush)
// PORTS
//  clk       in   1        rising-edge clock
//  rst_n     in   1        asynchronous active-low reset
//  valid_in  in   1        request; accepted when valid_in && in_ready
//  branch    in   1        instruction is a branch (0 = resolves not-taken)
//  cond      in   3        condition select (see BEHAVIOUR)
//  rd1       in   WIDTH    operand A
//  rd15      in   WIDTH    operand B
//  pc_in     in   PC_W     PC of the branch instruction
//  offset    in   PC_W     two's-complement branch displacement
//  kill      in   1        synchronous abort of any in-flight resolution
//  in_ready  out  1        high only in IDLE
//  res_valid out  1        one-cycle result strobe
//  pcsrc     out  1        1 = select target; valid with res_valid, else 0
//  target    out  PC_W     pc_in + offset, mod 2^PC_W; held until next result
//  flush     out  1        squash younger pipeline stages
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, all outputs 0 except in_ready=1.
//    Reset mid-EVAL/FLUSH aborts with no res_valid.
//  - FSM IDLE->EVAL on accept; operands, cond, branch, pc_in, offset are registered.
//  - EVAL: compare registered operands. On the next edge: res_valid=1,
//    pcsrc=taken, target registered. Go to FLUSH if taken && FLUSH_CYCLES>0,
//    otherwise IDLE.
//  - Latency: accept edge E0 -> res_valid high in the cycle after E1 (2 cycles).
//    Not-taken throughput is 1 per 2 cycles.
//  - FLUSH: flush=1 for exactly FLUSH_CYCLES cycles, starting in the cycle
//    res_valid is high. A down-counter is loaded with FLUSH_CYCLES-1; at 0 the
//    FSM goes to IDLE.
//  - in_ready=0 in EVAL and FLUSH. valid_in outside IDLE is ignored, not queued.
//  - cond: 000 EQ; 001 NE; 010 LT signed; 011 GE signed; 100 LTU; 101 GEU;
//    110 ALWAYS; 111 NEVER.
//  - branch=0 forces taken=0 regardless of cond. res_valid still pulses.
//  - target: pc_in + offset, truncated to PC_W (wraps, no overflow flag).
//  - kill=1: next edge goes to IDLE, clears flush and the counter, and
//    suppresses a pending res_valid.
//  - kill and valid_in together in IDLE: kill wins, no accept.
//  - res_valid and pcsrc are single-cycle. pcsrc=0 whenever res_valid=0.
// CONFIGURATION
//  BRANCH_STATS_EN defined: adds outputs taken_cnt[15:0] and ntaken_cnt[15:0].
//    Each increments on res_valid by outcome and saturates at 16'hFFFF.
//    Both are cleared by reset only; kill does not clear them.
//  BRANCH_STATS_EN undefined: no counters and no extra ports; all other
//    behaviour is identical.
// TESTING
//  1 EQ taken: rd1=5, rd15=5, cond=000, branch=1, pc_in=16'h0010, offset=16'h0004
//    -> res_valid 2 cycles after accept; pcsrc=1; target=16'h0014;
//    flush high 2 cycles; in_ready low 3 cycles.
//  2 Signed vs unsigned: rd1=16'hFFFF, rd15=1; cond=010 -> pcsrc=1;
//    cond=100 -> pcsrc=0, flush never asserts.
//  3 branch=0 with cond=110 -> res_valid=1, pcsrc=0, no flush, in_ready back in 1 cycle.
//  4 Wrap: pc_in=16'hFFFE, offset=16'h0004, cond=110 -> target=16'h0002.
//    Negative offset 16'hFFFC from pc_in=16'h0002 -> 16'hFFFE.
//  5 kill asserted in EVAL -> no res_valid, flush=0, in_ready=1 next cycle.
//    kill in the 1st FLUSH cycle -> flush drops after 1 cycle.
//  6 rst_n pulsed low mid-FLUSH -> outputs 0 immediately, in_ready=1.
//    With BRANCH_STATS_EN, counters=0 after 3 taken + 2 not-taken, then reset.

Source files
------------

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Registered branch resolver. Compares rd1 against rd15 under a
//                selectable condition, computes pc_in + offset and, on a taken
//                branch, holds flush for FLUSH_CYCLES cycles.
//                Optional feature macro: BRANCH_STATS_EN adds saturating
//                taken/not-taken outcome counters (taken_cnt, ntaken_cnt).
//  Revision    : 1.0  initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int WIDTH        = 16,
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             branch,
    input  logic [2:0]       cond,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd15,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [PC_W-1:0]  offset,
    input  logic             kill,
    output logic             in_ready,
    output logic             res_valid,
    output logic             pcsrc,
    output logic [PC_W-1:0]  target,
`ifdef BRANCH_STATS_EN
    output logic [15:0]      taken_cnt,
    output logic [15:0]      ntaken_cnt,
`endif
    output logic             flush
);

    // Counter only needs to hold FLUSH_CYCLES-1; keep at least one bit so the
    // FLUSH_CYCLES=0 and 1 builds stay legal.
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;

    localparam logic [2:0] COND_EQ     = 3'b000;
    localparam logic [2:0] COND_NE     = 3'b001;
    localparam logic [2:0] COND_LT     = 3'b010;
    localparam logic [2:0] COND_GE     = 3'b011;
    localparam logic [2:0] COND_LTU    = 3'b100;
    localparam logic [2:0] COND_GEU    = 3'b101;
    localparam logic [2:0] COND_ALWAYS = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   rd1_q;
    logic [WIDTH-1:0]   rd15_q;
    logic [2:0]         cond_q;
    logic               branch_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    off_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               res_valid_q;
    logic               pcsrc_q;
    logic [PC_W-1:0]    target_q;
    logic               flush_q;
    logic               taken_d;

    // Branch outcome from the operands captured at accept; a non-branch never takes.
    always_comb begin
        taken_d = 1'b0;
        case (cond_q)
            COND_EQ:     taken_d = (rd1_q == rd15_q);
            COND_NE:     taken_d = (rd1_q != rd15_q);
            COND_LT:     taken_d = ($signed(rd1_q) <  $signed(rd15_q));
            COND_GE:     taken_d = ($signed(rd1_q) >= $signed(rd15_q));
            COND_LTU:    taken_d = (rd1_q <  rd15_q);
            COND_GEU:    taken_d = (rd1_q >= rd15_q);
            COND_ALWAYS: taken_d = 1'b1;
            default:     taken_d = 1'b0;
        endcase
        if (!branch_q) begin
            taken_d = 1'b0;
        end
    end

    // Control FSM with registered result, target and flush outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd1_q       <= '0;
            rd15_q      <= '0;
            cond_q      <= '0;
            branch_q    <= 1'b0;
            pc_q        <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            pcsrc_q     <= 1'b0;
            target_q    <= '0;
            flush_q     <= 1'b0;
        end else begin
            // Result strobes are single-cycle by construction.
            res_valid_q <= 1'b0;
            pcsrc_q     <= 1'b0;
            if (kill) begin
                // Abort beats any accept or pending result.
                state_q <= ST_IDLE;
                flush_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (valid_in) begin
                            rd1_q    <= rd1;
                            rd15_q   <= rd15;
                            cond_q   <= cond;
                            branch_q <= branch;
                            pc_q     <= pc_in;
                            off_q    <= offset;
                            state_q  <= ST_EVAL;
                        end
                    end
                    ST_EVAL: begin
                        res_valid_q <= 1'b1;
                        pcsrc_q     <= taken_d;
                        target_q    <= pc_q + off_q;
                        if (taken_d && (FLUSH_CYCLES > 0)) begin
                            state_q <= ST_FLUSH;
                            flush_q <= 1'b1;
                            cnt_q   <= CNT_LOAD;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_FLUSH: begin
                        if (cnt_q == '0) begin
                            state_q <= ST_IDLE;
                            flush_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        flush_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_q;
    logic [15:0] ntaken_cnt_q;

    // Saturating outcome counters, bumped on the edge that raises res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q  <= '0;
            ntaken_cnt_q <= '0;
        end else if ((state_q == ST_EVAL) && !kill) begin
            if (taken_d) begin
                if (taken_cnt_q != 16'hFFFF) begin
                    taken_cnt_q <= taken_cnt_q + 16'd1;
                end
            end else begin
                if (ntaken_cnt_q != 16'hFFFF) begin
                    ntaken_cnt_q <= ntaken_cnt_q + 16'd1;
                end
            end
        end
    end

    assign taken_cnt  = taken_cnt_q;
    assign ntaken_cnt = ntaken_cnt_q;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign res_valid = res_valid_q;
    assign pcsrc     = pcsrc_q;
    assign target    = target_q;
    assign flush     = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_unit
//  Description : Self-checking bench for branch_resolve_unit: a table of
//                directed vectors plus hand-written kill/reset/throughput
//                sequences.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_branch_resolve_unit;

    localparam int WIDTH = 16;
    localparam int PC_W  = 16;

    logic             clk;
    logic             rst_n;
    logic             valid_in;
    logic             branch;
    logic [2:0]       cond;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd15;
    logic [PC_W-1:0]  pc_in;
    logic [PC_W-1:0]  offset;
    logic             kill;
    logic             in_ready;
    logic             res_valid;
    logic             pcsrc;
    logic [PC_W-1:0]  target;
    logic             flush;
`ifdef BRANCH_STATS_EN
    logic [15:0]      taken_cnt;
    logic [15:0]      ntaken_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    branch_resolve_unit #(
        .WIDTH        (WIDTH),
        .PC_W         (PC_W),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .branch     (branch),
        .cond       (cond),
        .rd1        (rd1),
        .rd15       (rd15),
        .pc_in      (pc_in),
        .offset     (offset),
        .kill       (kill),
        .in_ready   (in_ready),
        .res_valid  (res_valid),
        .pcsrc      (pcsrc),
        .target     (target),
`ifdef BRANCH_STATS_EN
        .taken_cnt  (taken_cnt),
        .ntaken_cnt (ntaken_cnt),
`endif
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic [2:0]  cnd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] pc;
        logic [15:0] off;
        logic        exp_taken;
        logic [15:0] exp_target;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic [2:0] cnd, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] pc, input logic [15:0] off);
        valid_in = 1'b1;
        branch   = br;
        cond     = cnd;
        rd1      = a;
        rd15     = b;
        pc_in    = pc;
        offset   = off;
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        branch   = 1'b0;
        cond     = 3'b000;
        rd1      = '0;
        rd15     = '0;
        pc_in    = '0;
        offset   = '0;
        kill     = 1'b0;

        //            br  cond    rd1      rd15     pc       off      tk  target
        vecs[0]  = '{1'b1, 3'b000, 16'h0005, 16'h0005, 16'h0010, 16'h0004, 1'b1, 16'h0014};
        vecs[1]  = '{1'b1, 3'b010, 16'hFFFF, 16'h0001, 16'h0100, 16'h0010, 1'b1, 16'h0110};
        vecs[2]  = '{1'b1, 3'b100, 16'hFFFF, 16'h0001, 16'h0100, 16'h0010, 1'b0, 16'h0110};
        vecs[3]  = '{1'b0, 3'b110, 16'h0000, 16'h0000, 16'h0200, 16'h0002, 1'b0, 16'h0202};
        vecs[4]  = '{1'b1, 3'b110, 16'h0000, 16'h0000, 16'hFFFE, 16'h0004, 1'b1, 16'h0002};
        vecs[5]  = '{1'b1, 3'b110, 16'h0000, 16'h0000, 16'h0002, 16'hFFFC, 1'b1, 16'hFFFE};
        vecs[6]  = '{1'b1, 3'b001, 16'h0003, 16'h0004, 16'h0000, 16'h0008, 1'b1, 16'h0008};
        vecs[7]  = '{1'b1, 3'b011, 16'h8000, 16'h0001, 16'h1000, 16'h0000, 1'b0, 16'h1000};
        vecs[8]  = '{1'b1, 3'b101, 16'h8000, 16'h0001, 16'h1000, 16'h0020, 1'b1, 16'h1020};
        vecs[9]  = '{1'b1, 3'b111, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 3'b000, 16'h0005, 16'h0006, 16'h0030, 16'h0002, 1'b0, 16'h0032};

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_pcsrc", pcsrc, 0);
        chk("rst_target", target, 0);
        chk("rst_flush", flush, 0);
        step();
        rst_n = 1'b1;
        step();

        // Table-driven vectors: accept, EVAL, result, then flush window if taken
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].br, vecs[i].cnd, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].off);
            step();
            valid_in = 1'b0;
            chk($sformatf("v%0d_eval_ready", i), in_ready, 0);
            chk($sformatf("v%0d_eval_rv", i), res_valid, 0);
            step();
            chk($sformatf("v%0d_rv", i), res_valid, 1);
            chk($sformatf("v%0d_pcsrc", i), pcsrc, vecs[i].exp_taken);
            chk($sformatf("v%0d_target", i), target, vecs[i].exp_target);
            chk($sformatf("v%0d_flush1", i), flush, vecs[i].exp_taken);
            chk($sformatf("v%0d_ready1", i), in_ready, !vecs[i].exp_taken);
            if (vecs[i].exp_taken) begin
                step();
                chk($sformatf("v%0d_rv_pulse", i), res_valid, 0);
                chk($sformatf("v%0d_pcsrc_pulse", i), pcsrc, 0);
                chk($sformatf("v%0d_flush2", i), flush, 1);
                chk($sformatf("v%0d_ready2", i), in_ready, 0);
                step();
                chk($sformatf("v%0d_flush_end", i), flush, 0);
                chk($sformatf("v%0d_ready_end", i), in_ready, 1);
                chk($sformatf("v%0d_target_hold", i), target, vecs[i].exp_target);
            end else begin
                step();
                chk($sformatf("v%0d_rv_pulse", i), res_valid, 0);
                chk($sformatf("v%0d_no_flush", i), flush, 0);
            end
        end

        // Back-to-back not-taken: second accept in the res_valid cycle
        drive(1'b1, 3'b000, 16'h0001, 16'h0002, 16'h0040, 16'h0001);
        step();
        valid_in = 1'b0;
        step();
        chk("b2b_rv1", res_valid, 1);
        chk("b2b_tgt1", target, 16'h0041);
        drive(1'b1, 3'b111, 16'h0000, 16'h0000, 16'h0050, 16'h0003);
        step();
        valid_in = 1'b0;
        chk("b2b_busy", in_ready, 0);
        step();
        chk("b2b_rv2", res_valid, 1);
        chk("b2b_pcsrc2", pcsrc, 0);
        chk("b2b_tgt2", target, 16'h0053);
        step();

        // kill during EVAL: no result, straight back to IDLE
        drive(1'b1, 3'b110, 16'h0000, 16'h0000, 16'h0300, 16'h0010);
        step();
        valid_in = 1'b0;
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_eval_rv", res_valid, 0);
        chk("kill_eval_flush", flush, 0);
        chk("kill_eval_ready", in_ready, 1);
        step();
        chk("kill_eval_rv_late", res_valid, 0);

        // kill together with valid_in in IDLE: no accept
        drive(1'b1, 3'b110, 16'h0000, 16'h0000, 16'h0400, 16'h0010);
        kill = 1'b1;
        step();
        kill = 1'b0;
        valid_in = 1'b0;
        chk("kill_idle_ready", in_ready, 1);
        step();
        chk("kill_idle_rv", res_valid, 0);

        // kill in the first FLUSH cycle: flush lasts a single cycle
        drive(1'b1, 3'b110, 16'h0000, 16'h0000, 16'h0500, 16'h0001);
        step();
        valid_in = 1'b0;
        step();
        chk("kill_fl_rv", res_valid, 1);
        chk("kill_fl_flush1", flush, 1);
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_fl_flush2", flush, 0);
        chk("kill_fl_ready", in_ready, 1);

        // valid_in held while busy is ignored, not queued
        drive(1'b1, 3'b110, 16'h0000, 16'h0000, 16'h0600, 16'h0002);
        step();
        step();
        chk("busy_rv", res_valid, 1);
        chk("busy_tgt", target, 16'h0602);
        step();
        valid_in = 1'b0;
        step();
        chk("busy_ready", in_ready, 1);
        step();
        chk("busy_no_queue_ready", in_ready, 1);
        chk("busy_no_queue_rv", res_valid, 0);

        // Async reset in the middle of FLUSH
        drive(1'b1, 3'b110, 16'h0000, 16'h0000, 16'h0700, 16'h0003);
        step();
        valid_in = 1'b0;
        step();
        chk("rstfl_flush", flush, 1);
`ifdef BRANCH_STATS_EN
        // taken: 6 table + kill-in-flush + busy + this one; not-taken: 5 table + 2 b2b
        chk("stats_taken", taken_cnt, 9);
        chk("stats_ntaken", ntaken_cnt, 7);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstfl_flush0", flush, 0);
        chk("rstfl_ready", in_ready, 1);
        chk("rstfl_rv", res_valid, 0);
        chk("rstfl_target", target, 0);
`ifdef BRANCH_STATS_EN
        chk("stats_taken_rst", taken_cnt, 0);
        chk("stats_ntaken_rst", ntaken_cnt, 0);
`endif
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_rv", res_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
